// File: rtl/moxie_wb_pkg.sv
// Shared Wishbone definitions: bus field widths, responder FSM states and
// the base-window address decode used by every on-chip responder.
package moxie_wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // True when adr falls in the naturally aligned window at base whose
  // size is 2^lsb bytes: every bit from lsb upwards must match.
  function automatic logic wb_hit(input logic [WB_ADR_W-1:0] adr,
                                  input logic [WB_ADR_W-1:0] base,
                                  input int unsigned         lsb);
    logic [WB_ADR_W-1:0] mask;
    mask = '1 << lsb;
    return ((adr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/moxie_wb_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port (data appears the cycle after the read is issued).
module moxie_wb_ram_array
  import moxie_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WB_SEL_W-1:0]   sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DAT_W-1:0]   wdata,
  output logic [WB_DAT_W-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WB_DAT_W-1:0] mem [DEPTH];

  // Byte-masked write or full-word registered read, one access per cycle.
  // NOTE: the storage array has no reset; a reset loop over every word
  // would stop it mapping onto a RAM macro, and contents are retained.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
          if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/moxie_wb_ram.sv
// Wishbone classic responder in front of a byte-writable word RAM.
// Decodes a base window, inserts WAIT_STATES cycles, terminates every
// strobe with one registered ack or err, and abandons the transfer if the
// initiator drops cyc while waiting.
module moxie_wb_ram
  import moxie_wb_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 12,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                  WAIT_STATES = 1,
  parameter bit                  READ_ONLY   = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  err_pend, err_pend_nxt;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [WB_DAT_W-1:0]   wdat_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic                  we_q;

  logic                  ram_access, ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WB_DAT_W-1:0]   ram_wdata, ram_rdata;
  logic [WB_SEL_W-1:0]   ram_sel;

  logic req, hit, refuse;

  assign req    = wb_cyc_i & wb_stb_i;
  assign hit    = wb_hit(wb_adr_i, BASE_ADDR, ADDR_WIDTH + 2);
  assign refuse = ~hit | (READ_ONLY & wb_we_i);

  // Reset at the commit edge must drop a pending write.
  assign ram_en = ram_access & rst_i;

  // Next-state, wait counter and RAM access selection.
  // NOTE: every signal assigned here gets a default first so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    err_pend_nxt = err_pend;
    ram_access   = 1'b0;
    ram_we       = we_q;
    ram_addr     = idx_q;
    ram_wdata    = wdat_q;
    ram_sel      = sel_q;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (refuse) begin
            err_pend_nxt = 1'b1;
            state_nxt    = ST_RESP;
          end else begin
            err_pend_nxt = 1'b0;
            if (WS == 4'd0) begin
              // No wait states: access straight from the bus this edge.
              ram_access = 1'b1;
              ram_we     = wb_we_i;
              ram_addr   = wb_adr_i[ADDR_WIDTH+1:2];
              ram_wdata  = wb_dat_i;
              ram_sel    = wb_sel_i;
              state_nxt  = ST_RESP;
            end else begin
              cnt_nxt   = WS;
              state_nxt = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd1) begin
          ram_access = 1'b1;
          state_nxt  = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered bus outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      err_pend <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err_pend <= err_pend_nxt;
      wb_ack_o <= (state == ST_RESP) & ~err_pend;
      wb_err_o <= (state == ST_RESP) & err_pend;
      if (state == ST_RESP) begin
        if (err_pend)   wb_dat_o <= '0;
        else if (!we_q) wb_dat_o <= ram_rdata;
      end
    end
  end

  // Request capture; plain datapath registers, only meaningful after IDLE
  // accepts a request, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && req) begin
      idx_q  <= wb_adr_i[ADDR_WIDTH+1:2];
      wdat_q <= wb_dat_i;
      sel_q  <= wb_sel_i;
      we_q   <= wb_we_i;
    end
  end

  moxie_wb_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .sel   (ram_sel),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_moxie_wb_ram.sv
// Self-checking bench for moxie_wb_ram. Three instances share one bus and
// are selected by gating cyc: WAIT_STATES=1, WAIT_STATES=3, and READ_ONLY.
module tb_moxie_wb_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  int          cur;
  logic [2:0]  cyc_v;
  logic [31:0] dat0, dat1, dat2;
  logic        ack0, ack1, ack2, err0, err1, err2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [int];
  logic [31:0] last_dat [3];

  assign cyc_v = {cyc && cur == 2, cyc && cur == 1, cyc && cur == 0};

  always #5 clk = ~clk;

  moxie_wb_ram #(.WAIT_STATES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0));

  moxie_wb_ram #(.WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1));

  moxie_wb_ram #(.WAIT_STATES(1), .READ_ONLY(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2));

  function automatic logic ack_of(input int d);
    return (d == 0) ? ack0 : (d == 1) ? ack1 : ack2;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err0 : (d == 1) ? err1 : err2;
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    return (d == 0) ? dat0 : (d == 1) ? dat1 : dat2;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transfer to instance d, entered and left on a falling edge.
  // lat counts falling edges from the request to the termination (0 = none).
  task automatic xfer(input int d, input logic [31:0] a_in, input logic [31:0] d_in,
                      input logic [3:0] s_in, input logic w_in,
                      output logic a, output logic e, output logic [31:0] rd,
                      output int lat);
    a = 1'b0; e = 1'b0; rd = '0; lat = 0;
    cur = d; adr = a_in; wdat = d_in; sel = s_in; we = w_in;
    stb = 1'b1; cyc = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_of(d) || err_of(d)) begin
        a = ack_of(d); e = err_of(d); rd = dat_of(d); lat = n;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("single_pulse", {30'd0, ack_of(d), err_of(d)}, 32'd0);
  endtask

  // Transfer with expectations derived from the window/wait/read-only rules.
  task automatic xfer_chk(input int d, input logic [31:0] a_in, input logic [31:0] d_in,
                          input logic [3:0] s_in, input logic w_in, input string tag,
                          output logic [31:0] rd);
    logic        a, e, ok;
    logic [31:0] exp_dat, old_w;
    int          lat, key;
    ok  = (a_in < 32'h0000_4000) && !(w_in && d == 2);
    key = d * 4096 + int'(a_in[13:2]);
    if (!ok)       exp_dat = '0;
    else if (w_in) exp_dat = last_dat[d];
    else           exp_dat = model.exists(key) ? model[key] : 32'h0;
    xfer(d, a_in, d_in, s_in, w_in, a, e, rd, lat);
    check({tag, "_ack"}, 32'(a), 32'(ok));
    check({tag, "_err"}, 32'(e), 32'(!ok));
    check({tag, "_lat"}, lat, ok ? ws_of(d) + 2 : 2);
    check({tag, "_dat"}, rd, exp_dat);
    if (ok && w_in) begin
      old_w = model.exists(key) ? model[key] : 32'h0;
      model[key] = merge(old_w, d_in, s_in);
    end
    if (!(ok && w_in)) last_dat[d] = exp_dat;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        a, e;
    logic [31:0] rd;
    int          lat, hits, acks, prev, idx, op, d;
    int          ack_at [4];

    for (int i = 0; i < 3; i++) last_dat[i] = '0;
    cur = 0; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;

    // Reset held three cycles with a write pending on the bus.
    rst = 1'b0; cur = 0; adr = 32'h40; wdat = 32'hA5A5_0F0F; sel = 4'hF; we = 1'b1;
    stb = 1'b1; cyc = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", 32'(ack0), 0);
      check("rst_err", 32'(err0), 0);
      check("rst_dat", dat0, 0);
    end
    rst = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack0) begin lat = n; break; end
    end
    stb = 1'b0; cyc = 1'b0;
    check("rst_release_lat", lat, 3);
    model[16] = 32'hA5A5_0F0F;
    @(negedge clk);

    // Write then read, full word, one wait state.
    xfer_chk(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, "wr_full", rd);
    xfer_chk(0, 32'h10, 32'h0,         4'hF, 1'b0, "rd_full", rd);

    // Byte enables over the previous word.
    xfer_chk(0, 32'h10, 32'h1122_3344, 4'b0101, 1'b1, "wr_bytes", rd);
    xfer_chk(0, 32'h10, 32'h0,         4'b0000, 1'b0, "rd_bytes", rd);
    check("bytes_value", rd, 32'hDE22_BE44);

    // Zero byte enables are still acknowledged and change nothing.
    xfer_chk(0, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, "wr_nosel", rd);
    xfer_chk(0, 32'h10, 32'h0,         4'hF,    1'b0, "rd_nosel", rd);

    // Outside the window.
    xfer_chk(0, 32'h0001_0000, 32'h0, 4'hF, 1'b0, "oor_read", rd);

    // Read-only instance refuses writes; contents stay as they were.
    xfer_chk(2, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b1, "ro_write", rd);
    xfer(2, 32'h10, 32'h0, 4'hF, 1'b0, a, e, rd, lat);
    check("ro_read_ack", 32'(a), 1);
    check("ro_unchanged", 32'(rd === 32'hCAFE_F00D), 0);

    // Fill sixteen words of both writable instances with random data.
    for (int i = 0; i < 16; i++) begin
      xfer_chk(0, 32'(i * 4), $urandom, 4'hF, 1'b1, "fill0", rd);
      xfer_chk(1, 32'(i * 4), $urandom, 4'hF, 1'b1, "fill1", rd);
    end

    // Abort: cyc dropped in the second wait cycle of a write (3 wait states).
    cur = 1; adr = 32'h20; wdat = 32'h5555_AAAA; sel = 4'hF; we = 1'b1;
    stb = 1'b1; cyc = 1'b1;
    hits = 0;
    @(negedge clk); if (ack1 || err1) hits++;
    @(negedge clk); if (ack1 || err1) hits++;
    stb = 1'b0; cyc = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack1 || err1) hits++;
    end
    check("abort_no_resp", hits, 0);
    xfer_chk(1, 32'h20, 32'h0, 4'hF, 1'b0, "abort_readback", rd);

    // Back-to-back: stb held for four reads, address advanced at each ack.
    cur = 1; adr = 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    acks = 0; hits = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (err1) hits++;
      if (ack1) begin
        ack_at[acks] = n;
        check("b2b_dat", dat1, model[4096 + acks]);
        last_dat[1] = model[4096 + acks];
        acks++;
        if (acks == 4) break;
        adr = 32'(acks * 4);
      end
    end
    stb = 1'b0; cyc = 1'b0;
    check("b2b_count", acks, 4);
    check("b2b_no_err", hits, 0);
    check("b2b_first", ack_at[0], 5);
    prev = ack_at[0];
    for (int i = 1; i < 4; i++) begin
      check("b2b_spacing", ack_at[i] - prev, 5);
      prev = ack_at[i];
    end
    @(negedge clk);
    check("b2b_tail", 32'(ack1), 0);

    // Reset asserted while a write waits for its commit edge.
    cur = 0; adr = 32'h30; wdat = 32'h0BAD_0BAD; sel = 4'hF; we = 1'b1;
    stb = 1'b1; cyc = 1'b1;
    @(negedge clk);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_ack", 32'(ack0), 0);
      check("midrst_dat", dat0, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) last_dat[i] = '0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || err0) hits++;
    end
    check("midrst_no_ack", hits, 0);
    xfer_chk(0, 32'h30, 32'h0, 4'hF, 1'b0, "midrst_readback", rd);

    // Random mix of reads, byte writes and misses on the writable instances.
    for (int i = 0; i < 40; i++) begin
      d   = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 15));
      case (op)
        0, 1: xfer_chk(d, 32'(idx * 4) + $urandom_range(0, 3), $urandom, 4'hF, 1'b0, "rnd_rd", rd);
        2:    xfer_chk(d, 32'(idx * 4), $urandom, 4'($urandom_range(0, 15)), 1'b1, "rnd_wr", rd);
        default: xfer_chk(d, 32'h0000_4000 | $urandom, $urandom, 4'hF, 1'($urandom_range(0, 1)),
                          "rnd_miss", rd);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moxie_wb_ram.md
# moxie_wb_ram

Wishbone classic (B3) responder fronting an on-chip, byte-writable, synchronous word RAM. It is the target end of the core's instruction and data Wishbone initiator ports, and one instance serves each bus. It decodes a base-address window, inserts a parameterised number of wait states, and answers each strobe with exactly one `wb_ack_o` or `wb_err_o`. It also aborts cleanly when the initiator drops `wb_cyc_i`.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; the window is 4·2^ADDR_WIDTH bytes.
- `BASE_ADDR`, default 32'h0000_0000: byte base of the window; it must be aligned to the window size.
- `WAIT_STATES`, default 1: extra cycles inserted before ack; legal range 0–15.
- `READ_ONLY`, default 0: when 1, writes are refused with `wb_err_o`.
- `clk_i`, in, 1: the single clock; all logic is on the rising edge.
- `rst_i`, in, 1: synchronous, active-low reset (0 = reset).
- `wb_adr_i`, in, 32: byte address; bits [1:0] are ignored.
- `wb_dat_i`, in, 32: write data.
- `wb_sel_i`, in, 4: byte enables; bit n selects `dat[8n+7:8n]`.
- `wb_we_i`, in, 1: 1 = write.
- `wb_cyc_i`, in, 1: bus cycle active.
- `wb_stb_i`, in, 1: transfer request.
- `wb_dat_o`, out, 32: read data.
- `wb_ack_o`, out, 1: normal termination.
- `wb_err_o`, out, 1: error termination.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - A request is `wb_cyc_i & wb_stb_i`. The block latches address, data, sel and we.
  - Address hit rule: `wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`. The word index is `wb_adr_i[ADDR_WIDTH+1:2]`.
  - A miss, or a write with READ_ONLY=1, goes directly to RESP with err pending. The RAM is not touched.
  - A hit goes to WAIT with counter = WAIT_STATES, or to RESP if WAIT_STATES=0.
- **WAIT:**
  - The counter decrements each cycle. At 1, the RAM access is issued and the next state is RESP.
  - If `wb_cyc_i` is 0 in any WAIT cycle, the transfer is aborted: return to IDLE, no RAM write, no ack or err.
- **RAM access:**
  - Write: bytes with sel=1 are committed on the edge entering RESP. sel=4'b0000 commits nothing but is still acked.
  - Read: the full word is returned regardless of sel.
- **RESP:**
  - Exactly one of `wb_ack_o`/`wb_err_o` is high for exactly one cycle. The next state is always IDLE.
  - A stb still high on the following IDLE cycle is treated as a new request (back-to-back).
- **Read data:** `wb_dat_o` is valid during the ack cycle and holds until the next read ack. It is 0 on err.
- **Reset:**
  - All outputs go to 0 and the FSM goes to IDLE. This applies mid-transfer too: any pending write is dropped if reset is asserted before the commit edge.
  - RAM contents are not reset.
- **Simultaneous events:** a cyc drop in the RESP cycle has no effect, because the ack or err is already committed.

## Timing
- Request sampled at edge E. Ack or err is high in the cycle after edge E+1+WAIT_STATES.
- With WAIT_STATES=0: request cycle, then ack cycle, so two cycles per transfer.
- Back-to-back throughput is one transfer per WAIT_STATES+2 cycles.
- Error latency is always two cycles (sample, then err), independent of WAIT_STATES.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `moxie_wb_pkg`:
  - the FSM state enum;
  - Wishbone field widths (DAT=32, ADR=32, SEL=4);
  - a `wb_hit` address-decode function, shared with future peripherals.
- Sub-module `moxie_wb_ram_array` is a single-port synchronous RAM with 4 byte-write enables and one-cycle registered read. It is sized to 2^ADDR_WIDTH words.

## Test plan
- **Reset:** hold `rst_i`=0 for 3 cycles with stb=1, then release. Required: ack, err and dat are 0 during reset, and the first ack arrives WAIT_STATES+2 cycles after release.
- **Write then read, WAIT_STATES=1:**
  - Write 32'hDEADBEEF to 0x0000_0010 with sel=4'hF. Required: ack on cycle 3.
  - Read 0x0000_0010. Required: ack with `wb_dat_o`=32'hDEADBEEF.
- **Byte enables:** write 32'h11223344 with sel=4'b0101 over 32'hDEADBEEF. Required: a readback of 32'hDE22BE44.
- **Out-of-range and READ_ONLY:**
  - Read 32'h0001_0000 (ADDR_WIDTH=12, BASE=0). Required: a single err pulse, no ack, dat=0.
  - Write with READ_ONLY=1. Required: err, and RAM unchanged on readback.
- **Abort and back-to-back, WAIT_STATES=3:**
  - Drop cyc in the second WAIT cycle of a write to 0x20. Required: no ack, and the old value is read back.
  - Hold stb for 4 consecutive reads. Required: acks exactly 5 cycles apart, never two in a row.
- **Reset mid-write:** assert `rst_i`=0 during WAIT. Required: the location is unchanged, and no ack follows reset release.
